// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel successive-approximation ADC controller with a channel-scan
// sequencer, continuous mode and a valid/ready result port.
// Optional averaging of 2**AVG_LOG2 passes per channel is compiled in with SAR_AVG_EN.
module sar_scan_ctrl #(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned SAMPLE_W   = 4,
  parameter int unsigned AVG_LOG2   = 2,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CHANNELS-1:0]   chan_mask_i,
  input  logic [SAMPLE_W-1:0]   sample_cycles_i,
  input  logic                  cont_i,
  input  logic                  comp_i,
  output logic                  sample_o,
  output logic [CH_W-1:0]       chan_sel_o,
  output logic [RESOLUTION-1:0] dac_o,
  output logic                  busy_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [RESOLUTION-1:0] res_data_o,
  output logic [CH_W-1:0]       res_chan_o
);

  typedef enum logic [1:0] {StIdle, StSample, StConvert, StResult} state_e;

  localparam logic [RESOLUTION-1:0] TrialMsb = {1'b1, {(RESOLUTION-1){1'b0}}};

  state_e                state_q, state_d;
  logic [CHANNELS-1:0]   mask_q, mask_d;
  logic [SAMPLE_W-1:0]   slen_q, slen_d;
  logic [SAMPLE_W-1:0]   cnt_q, cnt_d;
  logic [RESOLUTION-1:0] trial_q, trial_d;   // one-hot bit under test
  logic [RESOLUTION-1:0] bits_q, bits_d;     // bits already decided
  logic [CH_W-1:0]       chan_q, chan_d;
  logic [RESOLUTION-1:0] res_data_q, res_data_d;

`ifdef SAR_AVG_EN
  localparam int unsigned ACC_W  = RESOLUTION + AVG_LOG2;
  localparam int unsigned PASS_W = AVG_LOG2 + 1;
  localparam logic [PASS_W-1:0] LastPass = PASS_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [ACC_W-1:0]  acc_sum;
`endif

  logic [CH_W-1:0] low_in, low_q, next_chan;
  logic            has_next;

  function automatic logic [CH_W-1:0] lowest_set(input logic [CHANNELS-1:0] m);
    lowest_set = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  // Channel search: lowest set bit of the start mask / latched mask, and next set bit above
  // the current channel.
  always_comb begin
    low_in    = lowest_set(chan_mask_i);
    low_q     = lowest_set(mask_q);
    next_chan = '0;
    has_next  = 1'b0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(chan_q))) begin
        next_chan = CH_W'(i);
        has_next  = 1'b1;
      end
    end
  end

  // Sequencer next-state: sample timing, bit decisions and scan progression.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    slen_d     = slen_q;
    cnt_d      = cnt_q;
    trial_d    = trial_q;
    bits_d     = bits_q;
    chan_d     = chan_q;
    res_data_d = res_data_q;
`ifdef SAR_AVG_EN
    acc_d      = acc_q;
    pass_d     = pass_q;
    acc_sum    = '0;
`endif
    case (state_q)
      StIdle: begin
        if (start_i && (chan_mask_i != '0)) begin
          mask_d  = chan_mask_i;
          slen_d  = (sample_cycles_i == '0) ? SAMPLE_W'(1) : sample_cycles_i;
          chan_d  = low_in;
          cnt_d   = '0;
`ifdef SAR_AVG_EN
          pass_d  = '0;
`endif
          state_d = StSample;
        end
      end
      StSample: begin
        if (cnt_q == slen_q - SAMPLE_W'(1)) begin
          cnt_d   = '0;
          trial_d = TrialMsb;
          bits_d  = '0;
          state_d = StConvert;
        end else begin
          cnt_d = cnt_q + SAMPLE_W'(1);
        end
      end
      StConvert: begin
        if (comp_i) bits_d = bits_q | trial_q;
        trial_d = trial_q >> 1;
        if (trial_q[0]) begin
`ifdef SAR_AVG_EN
          // First pass of a channel overwrites the accumulator instead of adding to it.
          acc_sum = ((pass_q == '0) ? '0 : acc_q) + ACC_W'(bits_d);
          acc_d   = acc_sum;
          if (pass_q == LastPass) begin
            res_data_d = RESOLUTION'(acc_sum >> AVG_LOG2);
            state_d    = StResult;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            cnt_d   = '0;
            state_d = StSample;
          end
`else
          res_data_d = bits_d;
          state_d    = StResult;
`endif
        end
      end
      StResult: begin
        if (res_ready_i) begin
          cnt_d = '0;
`ifdef SAR_AVG_EN
          pass_d = '0;
`endif
          if (has_next) begin
            chan_d  = next_chan;
            state_d = StSample;
          end else if (cont_i) begin
            chan_d  = low_q;
            state_d = StSample;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any conversion in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      slen_q     <= '0;
      cnt_q      <= '0;
      trial_q    <= '0;
      bits_q     <= '0;
      chan_q     <= '0;
      res_data_q <= '0;
`ifdef SAR_AVG_EN
      acc_q      <= '0;
      pass_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      slen_q     <= slen_d;
      cnt_q      <= cnt_d;
      trial_q    <= trial_d;
      bits_q     <= bits_d;
      chan_q     <= chan_d;
      res_data_q <= res_data_d;
`ifdef SAR_AVG_EN
      acc_q      <= acc_d;
      pass_q     <= pass_d;
`endif
    end
  end

  // Outputs decoded from state; chan_q holds from SAMPLE entry through the handshake.
  always_comb begin
    sample_o    = (state_q == StSample);
    dac_o       = (state_q == StConvert) ? (bits_q | trial_q) : '0;
    busy_o      = (state_q != StIdle);
    res_valid_o = (state_q == StResult);
    chan_sel_o  = chan_q;
    res_chan_o  = chan_q;
    res_data_o  = res_data_q;
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed self-checking bench for sar_scan_ctrl (RESOLUTION=8, CHANNELS=4).
module tb_sar_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mask;
  logic [3:0] scyc;
  logic       cont;
  logic       comp;
  logic       sample;
  logic [1:0] chan_sel;
  logic [7:0] dac;
  logic       busy;
  logic       res_valid;
  logic       ready;
  logic [7:0] res_data;
  logic [1:0] res_chan;

  logic [7:0] vin [4];

  int n_checks = 0;
  int n_fail   = 0;

  sar_scan_ctrl #(
    .RESOLUTION(8),
    .CHANNELS  (4),
    .SAMPLE_W  (4),
    .AVG_LOG2  (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .chan_mask_i    (mask),
    .sample_cycles_i(scyc),
    .cont_i         (cont),
    .comp_i         (comp),
    .sample_o       (sample),
    .chan_sel_o     (chan_sel),
    .dac_o          (dac),
    .busy_o         (busy),
    .res_valid_o    (res_valid),
    .res_ready_i    (ready),
    .res_data_o     (res_data),
    .res_chan_o     (res_chan)
  );

  always #5 clk = ~clk;

  // Ideal comparator on the selected channel.
  always_comb comp = (vin[chan_sel] >= dac);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start-edge E happens inside; returns at the first SAMPLE cycle.
  task automatic launch(input logic [3:0] m, input logic [3:0] s);
    start = 1'b1;
    mask  = m;
    scyc  = s;
    tick();
    start = 1'b0;
    mask  = 4'h0;
    scyc  = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mask = '0; scyc = '0; cont = 1'b0; ready = 1'b0;
    for (int i = 0; i < 4; i++) vin[i] = 8'h00;
    tick();
    tick();
    n_checks++;
    if ({sample, chan_sel, dac, busy, res_valid, res_data, res_chan} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {sample, chan_sel, dac, busy, res_valid, res_data, res_chan});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy %b required 0", busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_dac [8];
    exp_dac = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin[0] = 8'hA5;
    launch(4'b0001, 4'd2);
    n_checks++;
    if ({sample, busy, chan_sel, dac} !== {1'b1, 1'b1, 2'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL single_sample1: got s%b b%b ch%0d dac%h required s1 b1 ch0 dac00",
               sample, busy, chan_sel, dac);
    end
    tick();
    n_checks++;
    if (sample !== 1'b1) begin
      n_fail++;
      $display("FAIL single_sample2: sample %b required 1", sample);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({dac, sample, res_valid} !== {exp_dac[k], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL single_dac%0d: dac %h s%b v%b required dac %h s0 v0",
                 k, dac, sample, res_valid, exp_dac[k]);
      end
      tick();
    end
    n_checks++;
    if ({res_valid, res_data, res_chan, dac} !== {1'b1, 8'hA5, 2'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL single_result: v%b data %h ch %0d dac %h required v1 data a5 ch 0 dac 00",
               res_valid, res_data, res_chan, dac);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: busy %b valid %b required 0 0", busy, res_valid);
    end
  endtask

  task automatic test_scan();
    int         nres = 0;
    int         cyc  = 0;
    bit         bad_sel = 1'b0;
    logic [7:0] rd [2];
    logic [1:0] rc [2];
    rd = '{8'h00, 8'h00};
    rc = '{2'd0, 2'd0};
    vin[1] = 8'h10;
    vin[3] = 8'hF0;
    ready  = 1'b1;
    launch(4'b1010, 4'd2);
    while (busy && cyc < 200) begin
      if (chan_sel == 2'd0 || chan_sel == 2'd2) bad_sel = 1'b1;
      if (res_valid) begin
        if (nres < 2) begin
          rd[nres] = res_data;
          rc[nres] = res_chan;
        end
        nres++;
      end
      tick();
      cyc++;
    end
    ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_busy_end: busy %b required 0", busy);
    end
    n_checks++;
    if (nres != 2) begin
      n_fail++;
      $display("FAIL scan_count: got %0d results required 2", nres);
    end
    n_checks++;
    if ({rc[0], rd[0]} !== {2'd1, 8'h10}) begin
      n_fail++;
      $display("FAIL scan_first: got ch %0d data %h required ch 1 data 10", rc[0], rd[0]);
    end
    n_checks++;
    if ({rc[1], rd[1]} !== {2'd3, 8'hF0}) begin
      n_fail++;
      $display("FAIL scan_second: got ch %0d data %h required ch 3 data f0", rc[1], rd[1]);
    end
    n_checks++;
    if (bad_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_unmasked_sel: channel 0 or 2 selected, flag %b required 0", bad_sel);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    vin[0] = 8'h33;
    vin[1] = 8'h66;
    ready  = 1'b0;
    launch(4'b0011, 4'd3);
    while (!res_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_valid: valid %b required 1", res_valid);
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({res_valid, res_data, chan_sel, dac, sample} !== {1'b1, 8'h33, 2'd0, 8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_stall%0d: v%b data %h ch %0d dac %h s%b required v1 33 ch0 00 s0",
                 i, res_valid, res_data, chan_sel, dac, sample);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if ({sample, chan_sel, res_valid} !== {1'b1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_release: s%b ch %0d v%b required s1 ch1 v0", sample, chan_sel, res_valid);
    end
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if ({res_valid, res_data, res_chan} !== {1'b1, 8'h66, 2'd1}) begin
      n_fail++;
      $display("FAIL bp_second: v%b data %h ch %0d required v1 66 ch1",
               res_valid, res_data, res_chan);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: busy %b required 0", busy);
    end
  endtask

  task automatic test_continuous();
    int nres = 0;
    int cyc  = 0;
    int vt [4];
    vt = '{0, 0, 0, 0};
    vin[0] = 8'h5A;
    ready  = 1'b1;
    cont   = 1'b1;
    launch(4'b0001, 4'd2);
    while (busy && cyc < 200) begin
      if (res_valid) begin
        if (nres < 4) vt[nres] = cyc;
        n_checks++;
        if (res_data !== 8'h5A) begin
          n_fail++;
          $display("FAIL cont_data%0d: got %h required 5a", nres, res_data);
        end
        nres++;
      end
      tick();
      cyc++;
      if (nres == 3) cont = 1'b0;
    end
    ready = 1'b0;
    cont  = 1'b0;
    n_checks++;
    if ({busy, nres} !== {1'b0, 32'd4}) begin
      n_fail++;
      $display("FAIL cont_count: busy %b results %0d required busy 0 results 4", busy, nres);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (vt[i] - vt[i-1] != 11) begin
        n_fail++;
        $display("FAIL cont_period%0d: got %0d cycles required 11", i, vt[i] - vt[i-1]);
      end
    end
  endtask

  task automatic test_zero_mask();
    start = 1'b1;
    mask  = 4'b0000;
    scyc  = 4'd2;
    tick();
    start = 1'b0;
    scyc  = 4'd0;
    n_checks++;
    if ({busy, sample} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_mask_start: busy %b sample %b required 0 0", busy, sample);
    end
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_mask_idle: busy %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    vin[2] = 8'hA5;
    launch(4'b0100, 4'd2);
    tick();
    tick();
    tick();
    tick();
    tick();
    n_checks++;
    if ({dac, chan_sel} !== {8'hB0, 2'd2}) begin
      n_fail++;
      $display("FAIL rstmid_pre: dac %h ch %0d required b0 ch2", dac, chan_sel);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sample, chan_sel, dac, busy, res_valid, res_data, res_chan} !== 23'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h required 0",
               {sample, chan_sel, dac, busy, res_valid, res_data, res_chan});
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_no_partial: busy %b valid %b required 0 0", busy, res_valid);
    end
    launch(4'b0100, 4'd2);
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_early: valid %b required 0", res_valid);
    end
    tick();
    n_checks++;
    if ({res_valid, res_data, res_chan} !== {1'b1, 8'hA5, 2'd2}) begin
      n_fail++;
      $display("FAIL rstmid_result: v%b data %h ch %0d required v1 a5 ch2",
               res_valid, res_data, res_chan);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

`ifdef SAR_AVG_EN
  task automatic test_avg();
    logic [7:0] pv [4];
    pv = '{8'h40, 8'h41, 8'h42, 8'h44};
    vin[0] = pv[0];
    launch(4'b0001, 4'd2);
    for (int p = 0; p < 4; p++) begin
      vin[0] = pv[p];
      for (int i = 0; i < 10; i++) begin
        if (p == 3 && i == 9) begin
          n_checks++;
          if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL avg_early: valid %b required 0", res_valid);
          end
        end
        tick();
      end
    end
    n_checks++;
    if ({res_valid, res_data, res_chan} !== {1'b1, 8'h41, 2'd0}) begin
      n_fail++;
      $display("FAIL avg_result: v%b data %h ch %0d required v1 41 ch0",
               res_valid, res_data, res_chan);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef SAR_AVG_EN
    test_avg();
`else
    test_single();
    test_scan();
    test_backpressure();
    test_continuous();
    test_zero_mask();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
